// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: store size encodings, store FSM states and size-to-byte-count helper
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      WRITE,
      ERR
   } state_e;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return (size == SZ_WORD) ? 4'd4 : (size == SZ_HALF) ? 4'd2 : (size == SZ_BYTE) ? 4'd1 : 4'd0;
   endfunction

endpackage

// File: rtl/lane_merge.sv
// lane_merge: replaces the addressed byte lanes of a memory word with store payload bytes
module lane_merge
   import cpu_mem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [DATA_W-1:0]          base,
   input  logic [31:0]                data,
   input  logic [1:0]                 size,
   input  logic [$clog2(DATA_W/8)-1:0] offset,
   output logic [DATA_W-1:0]          merged,
   output logic [DATA_W/8-1:0]        be
);

   localparam int NB = DATA_W / 8;

   logic [3:0] nb;
   logic [4:0] lane;

   assign nb   = size_bytes(size);
   // big-endian numbers lanes from the top, so the payload's lowest byte lands highest
   assign lane = BIG_ENDIAN ? 5'(NB) - 5'(nb) - 5'(offset) : 5'(offset);

   always_comb begin
      merged = base;
      be     = '0;
      for (int i = 0; i < NB; i++) begin
         if (5'(i) >= lane && 5'(i) < lane + 5'(nb)) begin
            be[i]            = 1'b1;
            merged[8*i +: 8] = 8'(data >> {5'(i) - lane, 3'b000});
         end
      end
   end

endmodule

// File: rtl/store_merge_rmw.sv
// store_merge_rmw: store unit that writes words directly and read-modify-writes halves and bytes
module store_merge_rmw
   import cpu_mem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [1:0]          req_size,
   input  logic [31:0]         req_data,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic                mem_rd_valid,
   input  logic [DATA_W-1:0]   mem_rd_data,
   output logic                mem_wr_en,
   output logic [DATA_W-1:0]   mem_wr_data,
   output logic [DATA_W/8-1:0] mem_be,
   output logic                done,
   output logic                misalign_exc
);

   localparam int NB = DATA_W / 8;
   localparam int OW = $clog2(NB);

   state_e              state, nxt;
   logic [ADDR_W-1:0]   addr_q;
   logic [1:0]          size_q;
   logic [31:0]         data_q;
   logic [DATA_W-1:0]   rd_q, merged;
   logic [NB-1:0]       be;
   logic                mis, accept;

   assign accept = req_valid && req_ready;
   assign mis    = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
                   req_size == SZ_RSVD;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (req_valid) nxt = mis ? ERR : (req_size == SZ_WORD) ? WRITE : READ;
         READ:    nxt = WAIT;
         WAIT:    if (mem_rd_valid) nxt = WRITE;
         default: nxt = IDLE;
      endcase
   end

   // word stores merge onto zero so unselected lanes go out as 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         addr_q <= '0;
         size_q <= '0;
         data_q <= '0;
         rd_q   <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            addr_q <= req_addr;
            size_q <= req_size;
            data_q <= req_data;
            rd_q   <= '0;
         end
         if (state == WAIT && mem_rd_valid) rd_q <= mem_rd_data;
      end
   end

   lane_merge #(.DATA_W(DATA_W), .BIG_ENDIAN(BIG_ENDIAN)) u_merge (
      .base   (rd_q),
      .data   (data_q),
      .size   (size_q),
      .offset (addr_q[OW-1:0]),
      .merged (merged),
      .be     (be)
   );

   assign req_ready    = state == IDLE;
   assign mem_rd_en    = state == READ;
   assign mem_wr_en    = state == WRITE;
   assign done         = state == WRITE;
   assign misalign_exc = state == ERR;
   assign mem_addr     = {addr_q[ADDR_W-1:OW], OW'(0)};
   assign mem_wr_data  = mem_wr_en ? merged : '0;
   assign mem_be       = mem_wr_en ? be : '0;

endmodule

// File: tb/tb_store_merge_rmw.sv
// tb_store_merge_rmw: scoreboard bench over LE32, BE32 and LE64 instances driven in lockstep
module tb_store_merge_rmw;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic [31:0] req_data = '0;
   logic        mem_rd_valid = 1'b0;
   logic [31:0] rd32 = '0;
   logic [63:0] rd64 = '0;

   logic [2:0]  ready, rd_en, wr_en, dn, exc;
   logic [31:0] maddr0, maddr1, maddr2;
   logic [31:0] wd0, wd1;
   logic [63:0] wd2;
   logic [3:0]  be0, be1;
   logic [7:0]  be2;

   logic [63:0] wd [3];
   logic [7:0]  bev [3];
   logic [71:0] exp_q [3][$];
   logic [71:0] last_w [3];
   int          rd_cnt [3];
   int          wr_cnt [3];
   int          exc_cnt [3];
   int          passed = 0;
   int          total = 0;

   always #5 clk = ~clk;

   store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b0)) dut0 (
      .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(ready[0]), .req_addr(req_addr),
      .req_size(req_size), .req_data(req_data), .mem_rd_en(rd_en[0]), .mem_addr(maddr0),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(rd32), .mem_wr_en(wr_en[0]), .mem_wr_data(wd0),
      .mem_be(be0), .done(dn[0]), .misalign_exc(exc[0]));

   store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b1)) dut1 (
      .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(ready[1]), .req_addr(req_addr),
      .req_size(req_size), .req_data(req_data), .mem_rd_en(rd_en[1]), .mem_addr(maddr1),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(rd32), .mem_wr_en(wr_en[1]), .mem_wr_data(wd1),
      .mem_be(be1), .done(dn[1]), .misalign_exc(exc[1]));

   store_merge_rmw #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(1'b0)) dut2 (
      .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(ready[2]), .req_addr(req_addr),
      .req_size(req_size), .req_data(req_data), .mem_rd_en(rd_en[2]), .mem_addr(maddr2),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(rd64), .mem_wr_en(wr_en[2]), .mem_wr_data(wd2),
      .mem_be(be2), .done(dn[2]), .misalign_exc(exc[2]));

   always_comb begin
      wd[0]  = {32'h0, wd0};
      wd[1]  = {32'h0, wd1};
      wd[2]  = wd2;
      bev[0] = {4'h0, be0};
      bev[1] = {4'h0, be1};
      bev[2] = be2;
   end

   // expected {be, data}: mask-and-shift view of the target lanes
   function automatic logic [71:0] model(input int nbw, input bit bem, input logic [31:0] a, input logic [1:0] s,
                                         input logic [31:0] d, input logic [63:0] base);
      int n, off, lane;
      logic [63:0] pm, m, dv, b;
      logic [7:0] bmask;
      n     = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
      off   = int'(a) & (nbw - 1);
      lane  = bem ? nbw - n - off : off;
      pm    = (64'd1 << (8 * n)) - 64'd1;
      m     = pm << (8 * lane);
      dv    = ({32'h0, d} & pm) << (8 * lane);
      bmask = 8'(((9'd1 << n) - 9'd1) << lane);
      b     = (s == 2'd0) ? 64'h0 : base;
      return {bmask, (b & ~m) | dv};
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (dn[i] !== wr_en[i] || (dn[i] && exc[i]))
               $display("FAIL strobe_pairing dut%0d done=%b wr_en=%b exc=%b", i, dn[i], wr_en[i], exc[i]);
            else passed++;
            total++;
            if (wr_en[i] !== 1'b1 && bev[i] !== 8'h0)
               $display("FAIL be_without_write dut%0d be=%h required 00", i, bev[i]);
            else passed++;
            if (rd_en[i] === 1'b1) rd_cnt[i]++;
            if (exc[i] === 1'b1) exc_cnt[i]++;
            if (wr_en[i] === 1'b1) begin
               logic [71:0] got, want;
               wr_cnt[i]++;
               got       = {bev[i], wd[i]};
               last_w[i] = got;
               total++;
               if (exp_q[i].size() == 0) $display("FAIL unexpected_write dut%0d got=%h", i, got);
               else begin
                  want = exp_q[i].pop_front();
                  if (got !== want) $display("FAIL write_word dut%0d got=%h required=%h", i, got, want);
                  else passed++;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                            input logic [31:0] r32, input logic [63:0] r64, input int w);
      bit mis;
      int r0 [3], w0 [3], e0 [3];
      mis = (s == 2'd1 && a[0]) || (s == 2'd0 && a[1:0] != 2'b00) || s == 2'd3;
      for (int i = 0; i < 3; i++) begin
         r0[i] = rd_cnt[i];
         w0[i] = wr_cnt[i];
         e0[i] = exc_cnt[i];
      end
      if (!mis) begin
         exp_q[0].push_back(model(4, 1'b0, a, s, d, {32'h0, r32}));
         exp_q[1].push_back(model(4, 1'b1, a, s, d, {32'h0, r32}));
         exp_q[2].push_back(model(8, 1'b0, a, s, d, r64));
      end
      req_valid = 1'b1;
      req_addr  = a;
      req_size  = s;
      req_data  = d;
      tick;
      req_valid = 1'b0;
      req_data  = $urandom;
      if (mis) begin
         total++;
         if (exc !== 3'b111) $display("FAIL misalign_pulse addr=%h exc=%b required 111", a, exc);
         else passed++;
         tick;
      end else if (s == 2'd0) begin
         tick;
      end else begin
         total++;
         if (rd_en !== 3'b111 || maddr0 !== {a[31:2], 2'b00} || maddr2 !== {a[31:3], 3'b000})
            $display("FAIL read_phase rd_en=%b addr32=%h addr64=%h", rd_en, maddr0, maddr2);
         else passed++;
         tick;
         repeat (w) tick;
         mem_rd_valid = 1'b1;
         rd32 = r32;
         rd64 = r64;
         tick;
         mem_rd_valid = 1'b0;
         rd32 = $urandom;
         rd64 = {$urandom, $urandom};
         total++;
         if (maddr1 !== {a[31:2], 2'b00} || maddr2 !== {a[31:3], 3'b000})
            $display("FAIL addr_stable addr32=%h addr64=%h", maddr1, maddr2);
         else passed++;
         tick;
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rd_cnt[i] - r0[i] != ((mis || s == 2'd0) ? 0 : 1) || wr_cnt[i] - w0[i] != (mis ? 0 : 1) ||
             exc_cnt[i] - e0[i] != (mis ? 1 : 0))
            $display("FAIL strobe_counts dut%0d addr=%h size=%0d rd=%0d wr=%0d exc=%0d", i, a, s,
                     rd_cnt[i] - r0[i], wr_cnt[i] - w0[i], exc_cnt[i] - e0[i]);
         else passed++;
      end
      total++;
      if (ready !== 3'b111) $display("FAIL ready_after addr=%h ready=%b required 111", a, ready);
      else passed++;
   endtask

   task automatic check_reset_outputs(input string tag);
      total++;
      if (ready !== 3'b111 || rd_en !== 3'b000 || wr_en !== 3'b000 || dn !== 3'b000 || exc !== 3'b000)
         $display("FAIL %s_ctrl ready=%b rd=%b wr=%b done=%b exc=%b", tag, ready, rd_en, wr_en, dn, exc);
      else passed++;
      total++;
      if (maddr0 !== 32'h0 || maddr1 !== 32'h0 || maddr2 !== 32'h0 || wd0 !== 32'h0 || wd1 !== 32'h0 ||
          wd2 !== 64'h0 || be0 !== 4'h0 || be1 !== 4'h0 || be2 !== 8'h0)
         $display("FAIL %s_data addr=%h/%h/%h wd=%h/%h/%h be=%h/%h/%h", tag, maddr0, maddr1, maddr2,
                  wd0, wd1, wd2, be0, be1, be2);
      else passed++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) tick;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_word_store;
      run_store(32'h100, 2'd0, 32'hDEADBEEF, 32'h0, 64'h0, 0);
      total++;
      if (last_w[0] !== {8'h0F, 32'h0, 32'hDEADBEEF})
         $display("FAIL word_0x100 got=%h required=%h", last_w[0], {8'h0F, 32'h0, 32'hDEADBEEF});
      else passed++;
      run_store(32'h204, 2'd0, 32'h01234567, 32'h0, 64'h0, 0);
   endtask

   task automatic test_byte_store;
      run_store(32'h103, 2'd2, 32'h000000AA, 32'h11223344, 64'h99887766_11223344, 3);
      total++;
      if (last_w[0] !== {8'h08, 32'h0, 32'hAA223344})
         $display("FAIL byte_le_0x103 got=%h required=%h", last_w[0], {8'h08, 32'h0, 32'hAA223344});
      else passed++;
   endtask

   task automatic test_half_store;
      run_store(32'h202, 2'd1, 32'h0000BEEF, 32'h11223344, 64'h55667788_11223344, 1);
      total++;
      if (last_w[1] !== {8'h03, 32'h0, 32'h1122BEEF})
         $display("FAIL half_be_0x202 got=%h required=%h", last_w[1], {8'h03, 32'h0, 32'h1122BEEF});
      else passed++;
   endtask

   task automatic test_misaligned;
      run_store(32'h101, 2'd1, 32'h1234, 32'h0, 64'h0, 0);
      run_store(32'h0, 2'd3, 32'h5678, 32'h0, 64'h0, 0);
      run_store(32'h102, 2'd0, 32'h9ABC, 32'h0, 64'h0, 0);
   endtask

   task automatic test_wide;
      run_store(32'h105, 2'd2, 32'h00000077, 32'h0, 64'h0, 0);
      total++;
      if (last_w[2] !== {8'h20, 64'h0000770000000000})
         $display("FAIL wide_byte_0x105 got=%h required=%h", last_w[2], {8'h20, 64'h0000770000000000});
      else passed++;
   endtask

   task automatic test_rd_valid_ignored;
      mem_rd_valid = 1'b1;
      rd32 = 32'hFFFFFFFF;
      rd64 = 64'hFFFFFFFF_FFFFFFFF;
      repeat (2) tick;
      mem_rd_valid = 1'b0;
      run_store(32'h301, 2'd2, 32'h0000005A, 32'hCAFEF00D, 64'h0BADF00D_CAFEF00D, 2);
   endtask

   task automatic test_reset_in_wait;
      int w0 [3];
      for (int i = 0; i < 3; i++) w0[i] = wr_cnt[i];
      req_valid = 1'b1;
      req_addr  = 32'h202;
      req_size  = 2'd1;
      req_data  = 32'h0000BEEF;
      tick;
      req_valid = 1'b0;
      tick;
      tick;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_in_wait");
      @(posedge clk);
      #1 rst_n = 1'b1;
      mem_rd_valid = 1'b1;
      rd32 = 32'h11223344;
      tick;
      mem_rd_valid = 1'b0;
      tick;
      tick;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (wr_cnt[i] != w0[i] || ready[i] !== 1'b1)
            $display("FAIL abandoned_wait dut%0d writes=%0d ready=%b required 0 and 1", i, wr_cnt[i] - w0[i], ready[i]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 24; k++)
         run_store($urandom, 2'($urandom_range(0, 3)), $urandom, $urandom, {$urandom, $urandom}, $urandom_range(0, 2));
      for (int i = 0; i < 3; i++) begin
         total++;
         if (exp_q[i].size() != 0) $display("FAIL scoreboard_drain dut%0d left=%0d required 0", i, exp_q[i].size());
         else passed++;
      end
   endtask

   initial begin
      test_reset;
      test_word_store;
      test_byte_store;
      test_half_store;
      test_misaligned;
      test_wide;
      test_rd_valid_ignored;
      test_reset_in_wait;
      test_back_to_back;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/store_merge_rmw.md
STORE_MERGE_RMW -- requirements
Module: store_merge_rmw

Interface
REQ-001: Parameter DATA_W, default 32, memory word width in bits; legal values 32 and 64.
REQ-002: Parameter ADDR_W, default 32, byte-address width.
REQ-003: Parameter BIG_ENDIAN, default 0; 0 selects little-endian lane numbering, 1 selects big-endian lane numbering.
REQ-004: Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005: Port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006: Port req_valid, input, 1, store request present.
REQ-007: Port req_ready, output, 1, block idle and able to accept a request.
REQ-008: Port req_addr, input, ADDR_W, byte address of the store.
REQ-009: Port req_size, input, 2, 00 word (32 bits), 01 half, 10 byte, 11 reserved.
REQ-010: Port req_data, input, 32, store source register; the payload is in its low-order bits.
REQ-011: Port mem_rd_en, output, 1, one-cycle read strobe.
REQ-012: Port mem_addr, output, ADDR_W, word-aligned address with the low log2(DATA_W/8) bits forced to 0.
REQ-013: Port mem_rd_valid, input, 1, read data valid.
REQ-014: Port mem_rd_data, input, DATA_W, read data.
REQ-015: Port mem_wr_en, output, 1, one-cycle write strobe.
REQ-016: Port mem_wr_data, output, DATA_W, merged write word.
REQ-017: Port mem_be, output, DATA_W/8, lanes modified by the write.
REQ-018: Port done, output, 1, one-cycle pulse on store completion.
REQ-019: Port misalign_exc, output, 1, one-cycle pulse on a rejected request.

Function
REQ-020: The FSM SHALL have the states IDLE, READ, WAIT, WRITE and ERR; req_ready SHALL be 1 only in IDLE.
REQ-021: A request is accepted when req_valid and req_ready are both 1; accepting it SHALL register the address, size and data.
REQ-022: A request SHALL be misaligned when the size is half and addr[0] is 1, when the size is word and addr[1:0] is not 0, or when the size is 11; an accepted misaligned request SHALL go IDLE->ERR->IDLE with misalign_exc=1 in ERR and no memory strobe.
REQ-023: An aligned word store SHALL go IDLE->WRITE->IDLE with no read.
  - Accept in cycle N, then mem_wr_en=1 and done=1 in cycle N+1.
  - The only lanes written are those selected by the address's offset within the memory word.
REQ-024: A half or byte store SHALL go IDLE->READ->WAIT->WRITE->IDLE.
  - mem_rd_en=1 for exactly one cycle in READ.
  - WAIT SHALL hold until mem_rd_valid=1 and SHALL capture mem_rd_data in that cycle.
  - WRITE follows on the next cycle.
REQ-025: mem_rd_valid SHALL be ignored outside WAIT.
REQ-026: Lane index SHALL be addr[log2(DATA_W/8)-1:0] when BIG_ENDIAN=0 and (DATA_W/8 - size_bytes - offset) when BIG_ENDIAN=1.
REQ-027: The merged word SHALL equal the captured read word with the selected lanes replaced by req_data[8*size_bytes-1:0]; for a word store, the unselected lanes of mem_wr_data SHALL be 0.
REQ-028: mem_addr SHALL be stable from READ through WRITE.
REQ-029: mem_be SHALL be nonzero only while mem_wr_en=1.
REQ-030: done and mem_wr_en SHALL be asserted in the same cycle, and done and misalign_exc SHALL never be asserted together.
REQ-031: Back-to-back operation SHALL be supported: a new request SHALL be acceptable in the first IDLE cycle after WRITE or ERR.

Reset
REQ-032: While reset=0, the block SHALL enter IDLE asynchronously and hold the following values:
  - req_ready=1.
  - mem_rd_en, mem_wr_en, done and misalign_exc = 0.
  - mem_addr, mem_wr_data and mem_be = 0.
REQ-033: Reset asserted in any state, including WAIT, SHALL abandon the operation without a write; a late mem_rd_valid SHALL then be ignored.

Structure
REQ-034: The size encodings, the state enumeration and the size-to-byte-count function SHALL reside in the shared package cpu_mem_pkg.
REQ-035: The lane merge SHALL be a combinational sub-module named lane_merge, parameterised by DATA_W and BIG_ENDIAN.

Verification
REQ-036: Word store, DATA_W=32, addr 0x100, data 0xDEADBEEF -> mem_wr_en and done in cycle N+1, mem_wr_data 0xDEADBEEF, mem_be 1111, no mem_rd_en.
REQ-037: Byte store, LE, addr 0x103, data 0x000000AA, read returns 0x11223344 after 3 WAIT cycles -> mem_addr 0x100, mem_wr_data 0xAA223344, mem_be 1000.
REQ-038: Half store, BIG_ENDIAN=1, addr 0x202, data 0x0000BEEF, read returns 0x11223344 -> mem_wr_data 0x1122BEEF, mem_be 0011.
REQ-039: Half at addr 0x101 and size 11 at addr 0x0 -> misalign_exc pulse each, no mem_rd_en or mem_wr_en, req_ready high on the following cycle.
REQ-040: Reset pulsed in WAIT, then mem_rd_valid=1 -> no mem_wr_en, no done, req_ready=1.
REQ-041: DATA_W=64, LE byte store at addr 0x105, data 0x77, read returns 0 -> mem_wr_data 0x0000770000000000, mem_be 0x20.
